// File: rtl/dl_rx_seq_checker.sv
// Receive-side DLL sequence checker: classifies each received TLP against
// NEXT_RCV_SEQ, tells the TL to accept or drop it, and schedules Ack/Nak
// DLLPs (AckNak latency timer, NAK_SCHEDULED) towards the DLLP arbiter.
module dl_rx_seq_checker #(
  parameter int SEQ_BITS    = 12,
  parameter int ACK_LATENCY = 255,
  parameter int CNT_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                link_up_i,
  input  logic                tlp_valid_i,
  input  logic [SEQ_BITS-1:0] tlp_seq_i,
  input  logic                tlp_lcrc_ok_i,
  output logic                tlp_accept_o,
  output logic                tlp_drop_o,
  output logic                dllp_valid_o,
  input  logic                dllp_ready_i,
  output logic                dllp_nak_o,
  output logic [SEQ_BITS-1:0] dllp_seq_o,
  output logic [SEQ_BITS-1:0] next_rcv_seq_o,
  output logic                nak_scheduled_o
);

  localparam logic [CNT_BITS-1:0] LAT_MAX  = CNT_BITS'(ACK_LATENCY);
  localparam logic [SEQ_BITS-1:0] SEQ_HALF = SEQ_BITS'(1 << (SEQ_BITS - 1));
  localparam logic [SEQ_BITS-1:0] SEQ_ONE  = SEQ_BITS'(1);

  logic [SEQ_BITS-1:0] next_rcv_seq_q, next_rcv_seq_d;
  logic                nak_sched_q, nak_sched_d;
  logic                ack_pend_q, ack_pend_d;
  logic                nak_pend_q, nak_pend_d;
  logic [CNT_BITS-1:0] lat_cnt_q, lat_cnt_d;
  logic                dllp_valid_q, dllp_valid_d;
  logic                dllp_nak_q, dllp_nak_d;
  logic [SEQ_BITS-1:0] dllp_seq_q, dllp_seq_d;
  logic                accept_q, accept_d;
  logic                drop_q, drop_d;

  logic [SEQ_BITS-1:0] seq_diff;
  logic [SEQ_BITS-1:0] last_seq;
  logic                handshake;
  logic                dllp_req;
  logic                is_dup;

  assign seq_diff  = next_rcv_seq_q - tlp_seq_i;
  assign last_seq  = next_rcv_seq_q - SEQ_ONE;
  assign handshake = dllp_valid_q & dllp_ready_i;
  assign dllp_req  = nak_pend_q | (ack_pend_q & (lat_cnt_q == LAT_MAX));
  assign is_dup    = (seq_diff != '0) && (seq_diff <= SEQ_HALF);

  // Next-state: handshake clear first, then timer, DLLP launch, then TLP
  // classification so that a same-cycle TLP event overrides the clear.
  always_comb begin
    next_rcv_seq_d = next_rcv_seq_q;
    nak_sched_d    = nak_sched_q;
    ack_pend_d     = ack_pend_q;
    nak_pend_d     = nak_pend_q;
    lat_cnt_d      = lat_cnt_q;
    dllp_valid_d   = dllp_valid_q;
    dllp_nak_d     = dllp_nak_q;
    dllp_seq_d     = dllp_seq_q;
    accept_d       = 1'b0;
    drop_d         = 1'b0;

    if (handshake) begin
      nak_pend_d   = 1'b0;
      // TLPs accepted while the DLLP was held are not covered by its seq;
      // keep the Ack owed for them so a later DLLP reports the newer seq.
      ack_pend_d   = (dllp_seq_q != last_seq);
      lat_cnt_d    = '0;
      dllp_valid_d = 1'b0;
    end else if (ack_pend_q && !nak_pend_q && (lat_cnt_q != LAT_MAX)) begin
      lat_cnt_d = lat_cnt_q + CNT_BITS'(1);
    end

    // Launch a DLLP; the Nak/seq fields are frozen until the handshake.
    if (!dllp_valid_q && dllp_req) begin
      dllp_valid_d = 1'b1;
      dllp_nak_d   = nak_pend_q;
      dllp_seq_d   = last_seq;
    end

    if (tlp_valid_i) begin
      if (tlp_lcrc_ok_i && (seq_diff == '0)) begin
        accept_d       = 1'b1;
        next_rcv_seq_d = next_rcv_seq_q + SEQ_ONE;
        nak_sched_d    = 1'b0;
        ack_pend_d     = 1'b1;
      end else if (tlp_lcrc_ok_i && is_dup) begin
        drop_d     = 1'b1;
        ack_pend_d = 1'b1;
        lat_cnt_d  = LAT_MAX;
      end else begin
        drop_d = 1'b1;
        if (!nak_sched_q) begin
          nak_sched_d = 1'b1;
          nak_pend_d  = 1'b1;
        end
      end
    end

    // DL_Inactive holds everything in the initial state.
    if (!link_up_i) begin
      next_rcv_seq_d = '0;
      nak_sched_d    = 1'b0;
      ack_pend_d     = 1'b0;
      nak_pend_d     = 1'b0;
      lat_cnt_d      = '0;
      dllp_valid_d   = 1'b0;
      dllp_nak_d     = 1'b0;
      dllp_seq_d     = '0;
      accept_d       = 1'b0;
      drop_d         = 1'b0;
    end
  end

  // State registers with asynchronous reset to the initial state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_rcv_seq_q <= '0;
      nak_sched_q    <= 1'b0;
      ack_pend_q     <= 1'b0;
      nak_pend_q     <= 1'b0;
      lat_cnt_q      <= '0;
      dllp_valid_q   <= 1'b0;
      dllp_nak_q     <= 1'b0;
      dllp_seq_q     <= '0;
      accept_q       <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      next_rcv_seq_q <= next_rcv_seq_d;
      nak_sched_q    <= nak_sched_d;
      ack_pend_q     <= ack_pend_d;
      nak_pend_q     <= nak_pend_d;
      lat_cnt_q      <= lat_cnt_d;
      dllp_valid_q   <= dllp_valid_d;
      dllp_nak_q     <= dllp_nak_d;
      dllp_seq_q     <= dllp_seq_d;
      accept_q       <= accept_d;
      drop_q         <= drop_d;
    end
  end

  assign tlp_accept_o    = accept_q;
  assign tlp_drop_o      = drop_q;
  assign dllp_valid_o    = dllp_valid_q;
  assign dllp_nak_o      = dllp_nak_q;
  assign dllp_seq_o      = dllp_seq_q;
  assign next_rcv_seq_o  = next_rcv_seq_q;
  assign nak_scheduled_o = nak_sched_q;

endmodule
